// File: rtl/ram_access_ctrl_pkg.sv
// Shared encodings and types for the two-port SRAM
// access controller.
package ram_access_ctrl_pkg;

  localparam int N_REQ = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic OP_WRITE_DEF = 1'b1;
  localparam logic OP_READ_DEF  = ~OP_WRITE_DEF;

  typedef struct packed {
    logic we;
    logic id;
  } txn_t;

endpackage

// File: rtl/ram_access_ctrl_rr_arbiter2.sv
// Two-request round-robin picker; the last-grant
// register lives in the parent.
module rr_arbiter2
  import ram_access_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_id
);

  always_comb begin
    gnt_id = 1'b0;
    unique case (1'b1)
      (req == 2'b11): gnt_id = ~last_grant;
      (req == 2'b10): gnt_id = 1'b1;
      default:        gnt_id = 1'b0;
    endcase
    gnt = {gnt_id, ~gnt_id} & {N_REQ{|req}};
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Shares one 8x8 SRAM macro between two requesters with
// setup/hold sequencing around ram_sel.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic        OP_WRITE      = OP_WRITE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [5:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic [2:0]  ram_addr,
  output logic [7:0]  ram_inp,
  output logic        ram_op,
  output logic        ram_sel,
  input  logic [7:0]  ram_outp,
  output logic        busy
);

  localparam logic [3:0] CNT_LOAD =
    4'(ACCESS_CYCLES - 1);

  logic [1:0]       st;
  logic [3:0]       cnt;
  logic             last_grant;
  txn_t             txn;
  logic [N_REQ-1:0] gnt;
  logic             gnt_id;
  logic             win_we;
  logic [2:0]       win_addr;
  logic [7:0]       win_wdata;

  rr_arbiter2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  assign win_we    = req_we[gnt_id];
  assign win_addr  = gnt_id ? req_addr[5:3]
                            : req_addr[2:0];
  assign win_wdata = gnt_id ? req_wdata[15:8]
                            : req_wdata[7:0];

  // Accept strobe is combinational so T is the cycle
  // the winner sees ready; masked while in reset.
  assign req_ready = (rst_n && st == ST_IDLE)
                   ? gnt : '0;
  assign busy = (st != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      txn        <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      ram_sel    <= 1'b0;
      ram_op     <= ~OP_WRITE;
      ram_addr   <= '0;
      ram_inp    <= '0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (|req_valid) begin
            txn        <= '{we: win_we, id: gnt_id};
            last_grant <= gnt_id;
            // addr/op/inp settle here, one cycle
            // ahead of sel
            ram_addr   <= win_addr;
            ram_op     <= win_we ? OP_WRITE
                                 : ~OP_WRITE;
            ram_inp    <= win_we ? win_wdata : '0;
            st         <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt     <= CNT_LOAD;
          ram_sel <= 1'b1;
          st      <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            ram_sel   <= 1'b0;
            rsp_rdata <= txn.we ? '0 : ram_outp;
            rsp_valid <= txn.id ? 2'b10 : 2'b01;
            st        <= ST_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (rsp_ready[txn.id]) begin
            rsp_valid <= '0;
            st        <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural
// SRAM model; a second instance runs ACCESS_CYCLES=1.
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_we = '0;
  logic [5:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  rsp_ready = 2'b11;
  logic        use_b = 1'b0;

  logic [1:0] req_ready_a, rsp_valid_a;
  logic [1:0] req_ready_b, rsp_valid_b;
  logic [7:0] rsp_rdata_a, ram_inp_a, ram_outp_a;
  logic [7:0] rsp_rdata_b, ram_inp_b, ram_outp_b;
  logic [2:0] ram_addr_a, ram_addr_b;
  logic       ram_op_a, ram_sel_a, busy_a;
  logic       ram_op_b, ram_sel_b, busy_b;

  logic [7:0] mem_a [8] = '{default: 8'h00};
  logic [7:0] mem_b [8] = '{default: 8'h00};

  logic [1:0] req_ready, rsp_valid;
  logic [7:0] rsp_rdata, ram_inp;
  logic [2:0] ram_addr;
  logic       ram_op, ram_sel, busy;

  int n_cmp = 0;
  int n_bad = 0;

  int         o_lat, o_sel, o_glitch, o_extra;
  int         o_unstable, o_busylow, o_vcnt;
  int         o_setup_bad;
  logic [7:0] o_rdata;

  always #5 clk = ~clk;

  ram_access_ctrl #(.ACCESS_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_a),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_a),
    .ram_addr(ram_addr_a), .ram_inp(ram_inp_a),
    .ram_op(ram_op_a), .ram_sel(ram_sel_a),
    .ram_outp(ram_outp_a), .busy(busy_a)
  );

  ram_access_ctrl #(.ACCESS_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_b),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_b),
    .ram_addr(ram_addr_b), .ram_inp(ram_inp_b),
    .ram_op(ram_op_b), .ram_sel(ram_sel_b),
    .ram_outp(ram_outp_b), .busy(busy_b)
  );

  // SRAM macro: write while sel & op, async read
  assign ram_outp_a = mem_a[ram_addr_a];
  assign ram_outp_b = mem_b[ram_addr_b];
  always @(posedge clk) begin
    if (ram_sel_a && ram_op_a)
      mem_a[ram_addr_a] <= ram_inp_a;
    if (ram_sel_b && ram_op_b)
      mem_b[ram_addr_b] <= ram_inp_b;
  end

  assign req_ready = use_b ? req_ready_b : req_ready_a;
  assign rsp_valid = use_b ? rsp_valid_b : rsp_valid_a;
  assign rsp_rdata = use_b ? rsp_rdata_b : rsp_rdata_a;
  assign ram_inp   = use_b ? ram_inp_b   : ram_inp_a;
  assign ram_addr  = use_b ? ram_addr_b  : ram_addr_a;
  assign ram_op    = use_b ? ram_op_b    : ram_op_a;
  assign ram_sel   = use_b ? ram_sel_b   : ram_sel_a;
  assign busy      = use_b ? busy_b      : busy_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(
    input int         r,
    input logic       we,
    input logic [2:0] a,
    input logic [7:0] d,
    input int         hold,
    input bit         raise_other
  );
    int         w;
    int         seen;
    bit         done;
    logic [2:0] pa;
    logic       po;
    o_lat = 0; o_sel = 0; o_glitch = 0; o_extra = 0;
    o_unstable = 0; o_busylow = 0; o_vcnt = 0;
    o_setup_bad = 0; o_rdata = 8'hxx;
    req_we[r] = we;
    req_addr[r*3 +: 3] = a;
    req_wdata[r*8 +: 8] = d;
    req_valid[r] = 1'b1;
    w = 0;
    #1;
    while (!req_ready[r] && w < 40) begin
      tick();
      #1;
      w++;
    end
    if (!req_ready[r]) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout req%0d: ready=%b want accept",
               r, req_ready);
      req_valid[r] = 1'b0;
      return;
    end
    if (req_ready != (r == 1 ? 2'b10 : 2'b01))
      o_extra++;
    pa = ram_addr;
    po = ram_op;
    tick();
    req_valid[r] = 1'b0;
    if (raise_other) req_valid[1-r] = 1'b1;
    seen = 0;
    done = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      rsp_ready[r] = (seen >= hold);
      #1;
      if (req_ready != 2'b00) o_extra++;
      if (rsp_valid[1-r]) o_extra++;
      if (!busy) o_busylow++;
      if (ram_sel) o_sel++;
      if (k == 1 && ram_sel) o_setup_bad++;
      if (ram_sel && (ram_addr != pa || ram_op != po))
        o_glitch++;
      pa = ram_addr;
      po = ram_op;
      if (rsp_valid[r]) begin
        if (seen == 0) begin
          o_lat = k;
          o_rdata = rsp_rdata;
        end else if (rsp_rdata !== o_rdata) begin
          o_unstable++;
        end
        seen++;
        done = rsp_ready[r];
      end
      tick();
    end
    o_vcnt = seen;
    rsp_ready[r] = 1'b1;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout req%0d: valid=%b want handshake",
               r, rsp_valid);
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 30 && busy; c++) tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_timeout: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    use_b = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (3) tick();
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rsp_rdata: got %h want 00", rsp_rdata); end
    n_cmp++; if (ram_sel !== 1'b0) begin n_bad++; $display("FAIL rst_ram_sel: got %b want 0", ram_sel); end
    n_cmp++; if (ram_op !== 1'b0) begin n_bad++; $display("FAIL rst_ram_op: got %b want 0", ram_op); end
    n_cmp++; if (ram_addr !== 3'd0) begin n_bad++; $display("FAIL rst_ram_addr: got %0d want 0", ram_addr); end
    n_cmp++; if (ram_inp !== 8'h00) begin n_bad++; $display("FAIL rst_ram_inp: got %h want 00", ram_inp); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if ({busy_b, ram_sel_b, rsp_valid_b} !== 4'b0) begin n_bad++; $display("FAIL rst_dut_b: got %b want 0000", {busy_b, ram_sel_b, rsp_valid_b}); end
    req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_ready_masked: got %b want 00", req_ready); end
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int         n;
    int         t[4];
    logic [3:0] ids;
    n = 0;
    ids = 4'b1111;
    t = '{default: 0};
    req_we = 2'b11;
    req_addr = {3'd2, 3'd1};
    req_wdata = {8'h22, 8'h11};
    req_valid = 2'b11;
    for (int c = 0; c < 60 && n < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        ids[n] = req_ready[1];
        t[n] = c;
        n++;
      end
      tick();
      if (n == 4) req_valid = 2'b00;
    end
    req_valid = 2'b00;
    n_cmp++; if (ids !== 4'b1010) begin n_bad++; $display("FAIL rr_order: got %b want 1010 (lsb first)", ids); end
    n_cmp++; if (t[1] - t[0] != 5) begin n_bad++; $display("FAIL rr_gap: got %0d want 5", t[1] - t[0]); end
    n_cmp++; if (t[3] - t[0] != 15) begin n_bad++; $display("FAIL rr_span: got %0d want 15", t[3] - t[0]); end
    wait_idle();
    run_txn(1, 1'b0, 3'd1, 8'h00, 0, 0);
    n_cmp++; if (o_rdata !== 8'h11) begin n_bad++; $display("FAIL rr_rd1: got %h want 11", o_rdata); end
    run_txn(0, 1'b0, 3'd2, 8'h00, 0, 0);
    n_cmp++; if (o_rdata !== 8'h22) begin n_bad++; $display("FAIL rr_rd2: got %h want 22", o_rdata); end
  endtask

  task automatic test_write_read();
    run_txn(0, 1'b1, 3'd3, 8'hA5, 0, 0);
    n_cmp++; if (o_sel != 2) begin n_bad++; $display("FAIL wr_sel_cycles: got %0d want 2", o_sel); end
    n_cmp++; if (o_setup_bad != 0) begin n_bad++; $display("FAIL wr_setup: got %0d want 0", o_setup_bad); end
    n_cmp++; if (o_lat != 4) begin n_bad++; $display("FAIL wr_latency: got %0d want 4", o_lat); end
    n_cmp++; if (o_extra != 0) begin n_bad++; $display("FAIL wr_strobes: got %0d want 0", o_extra); end
    n_cmp++; if (o_rdata !== 8'h00) begin n_bad++; $display("FAIL wr_rdata: got %h want 00", o_rdata); end
    run_txn(0, 1'b0, 3'd3, 8'h00, 0, 0);
    n_cmp++; if (o_rdata !== 8'hA5) begin n_bad++; $display("FAIL rd_rdata: got %h want a5", o_rdata); end
    n_cmp++; if (o_lat != 4) begin n_bad++; $display("FAIL rd_latency: got %0d want 4", o_lat); end
    n_cmp++; if (o_sel != 2) begin n_bad++; $display("FAIL rd_sel_cycles: got %0d want 2", o_sel); end
  endtask

  task automatic test_backpressure();
    run_txn(1, 1'b1, 3'd7, 8'h7E, 0, 0);
    req_we[0] = 1'b0;
    req_addr[2:0] = 3'd3;
    run_txn(1, 1'b0, 3'd7, 8'h00, 5, 1);
    n_cmp++; if (o_rdata !== 8'h7E) begin n_bad++; $display("FAIL bp_rdata: got %h want 7e", o_rdata); end
    n_cmp++; if (o_vcnt != 6) begin n_bad++; $display("FAIL bp_valid_cycles: got %0d want 6", o_vcnt); end
    n_cmp++; if (o_unstable != 0) begin n_bad++; $display("FAIL bp_stable: got %0d want 0", o_unstable); end
    n_cmp++; if (o_busylow != 0) begin n_bad++; $display("FAIL bp_busy: got %0d want 0", o_busylow); end
    n_cmp++; if (o_extra != 0) begin n_bad++; $display("FAIL bp_early_accept: got %0d want 0", o_extra); end
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_next_accept: got %b want 01", req_ready); end
    run_txn(0, 1'b0, 3'd3, 8'h00, 0, 0);
    n_cmp++; if (o_rdata !== 8'hA5) begin n_bad++; $display("FAIL bp_pending_rd: got %h want a5", o_rdata); end
  endtask

  task automatic test_sweep();
    int         g;
    logic [7:0] exp;
    g = 0;
    for (int a = 0; a < 8; a++) begin
      run_txn(0, 1'b1, 3'(a), 8'(8'h10 + a), 0, 0);
      g += o_glitch;
    end
    for (int a = 0; a < 8; a++) begin
      run_txn(a % 2, 1'b0, 3'(a), 8'h00, 0, 0);
      g += o_glitch;
      exp = 8'(8'h10 + a);
      n_cmp++; if (o_rdata !== exp) begin n_bad++; $display("FAIL sweep_rd%0d: got %h want %h", a, o_rdata, exp); end
    end
    n_cmp++; if (g != 0) begin n_bad++; $display("FAIL sweep_sel_vs_addr: got %0d want 0", g); end
  endtask

  task automatic test_reset_mid();
    int w;
    int stray;
    req_we[0] = 1'b1;
    req_addr[2:0] = 3'd4;
    req_wdata[7:0] = 8'hFF;
    req_valid[0] = 1'b1;
    w = 0;
    #1;
    while (!req_ready[0] && w < 20) begin
      tick();
      #1;
      w++;
    end
    tick();
    req_valid[0] = 1'b0;
    tick();
    #1;
    n_cmp++; if (ram_sel !== 1'b1) begin n_bad++; $display("FAIL rm_in_access: got %b want 1", ram_sel); end
    rst_n = 1'b0;
    tick();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_cmp++; if (ram_sel !== 1'b0) begin n_bad++; $display("FAIL rm_sel: got %b want 0", ram_sel); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rm_rsp_valid: got %b want 00", rsp_valid); end
    n_cmp++; if ({ram_addr, ram_op, ram_inp, rsp_rdata} !== 20'h0) begin n_bad++; $display("FAIL rm_outputs: got %h want 00000", {ram_addr, ram_op, ram_inp, rsp_rdata}); end
    rst_n = 1'b1;
    tick();
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (rsp_valid != 2'b00 || busy) stray++;
      tick();
    end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL rm_no_rsp: got %0d want 0", stray); end
    req_we = 2'b00;
    req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rm_first_win: got %b want 01", req_ready); end
    req_valid = 2'b00;
    tick();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL withdrawn_served: busy %b want 0", busy); end
    tick();
  endtask

  task automatic test_ac1();
    int n;
    int t[3];
    rst_n = 1'b0;
    req_valid = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    use_b = 1'b1;
    tick();
    run_txn(0, 1'b1, 3'd5, 8'h55, 0, 0);
    n_cmp++; if (o_lat != 3) begin n_bad++; $display("FAIL ac1_wr_latency: got %0d want 3", o_lat); end
    n_cmp++; if (o_sel != 1) begin n_bad++; $display("FAIL ac1_sel_cycles: got %0d want 1", o_sel); end
    run_txn(0, 1'b0, 3'd5, 8'h00, 0, 0);
    n_cmp++; if (o_lat != 3) begin n_bad++; $display("FAIL ac1_rd_latency: got %0d want 3", o_lat); end
    n_cmp++; if (o_rdata !== 8'h55) begin n_bad++; $display("FAIL ac1_rdata: got %h want 55", o_rdata); end
    n = 0;
    t = '{default: 0};
    req_we[0] = 1'b0;
    req_addr[2:0] = 3'd5;
    req_valid = 2'b01;
    for (int c = 0; c < 40 && n < 3; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        t[n] = c;
        n++;
      end
      tick();
      if (n == 3) req_valid = 2'b00;
    end
    req_valid = 2'b00;
    n_cmp++; if (n != 3 || t[2] - t[0] != 8) begin n_bad++; $display("FAIL ac1_throughput: %0d accepts span %0d want 3 span 8", n, t[2] - t[0]); end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_read();
    test_backpressure();
    test_sweep();
    test_reset_mid();
    test_ac1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

endmodule
